// File: rtl/ram_sync_clr_if.sv
// Bus bundle for ram_sync_clr: address/data/strobes in, registered read data and status out.
// master = bus driver (CPU side), slave = the RAM.
interface ram_sync_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic                  re;
  logic                  clear_req;
  logic                  par_inject;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  parity_err;

  modport master (
    output address, data_in, we, re, clear_req, par_inject,
    input  data_out, rd_valid, busy, parity_err
  );

  modport slave (
    input  address, data_in, we, re, clear_req, par_inject,
    output data_out, rd_valid, busy, parity_err
  );
endinterface

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with registered read, rd_valid strobe and a zero-fill sweep after reset / on request.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
//
// state | meaning
// CLEAR | zero-fill sweep, one word per edge; bus requests dropped, busy=1
// IDLE  | normal read/write service; clear_req starts a new sweep
module ram_sync_clr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ram_sync_clr_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic                  wr_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // clear_req wins over we/re on the same edge
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = bus.address;
    wr_data    = bus.data_in;
    rd_en      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        wr_data    = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          wr_en = bus.we;
          rd_en = bus.re;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // keeps the array untouched while reset is held even though the FSM sits in CLEAR
  assign mem_we = wr_en & reset_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read-first: the array update above lands after this sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        data_out_q <= mem[bus.address];
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == CLEAR);

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;
  logic par_err_q;

  assign wr_par = (state_q == CLEAR) ? 1'b0 : ((^bus.data_in) ^ bus.par_inject);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[wr_addr] <= wr_par;
    end
  end

  // cleared on every non-read edge so the flag never outlives rd_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= rd_en & ((^mem[bus.address]) != par_mem[bus.address]);
    end
  end

  assign bus.parity_err = par_err_q;
`else
  logic unused_par_inject;

  assign unused_par_inject = bus.par_inject;
  assign bus.parity_err    = 1'b0;
`endif

endmodule
